// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction register and return-address
// stack for the 19-bit CPU. Resolves JMP, BEQ, BNE, CALL and RET locally.
// Optional build macro: PC_STACK_CHECK_EN (guards CALL-on-full and RET-on-empty,
// raising sticky overflow/underflow flags). Without it the stack pointer wraps.
module pc_fetch_unit #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pc_enable,
    input  logic [1:0]                         pc_sel,
    input  logic                               load_ir,
    input  logic                               zero_flag,
    input  logic [18:0]                        imem_rdata,
    output logic [ADDR_W-1:0]                  imem_addr,
    output logic [ADDR_W-1:0]                  pc,
    output logic [18:0]                        ir,
    output logic [4:0]                         opcode,
    output logic [$clog2(STACK_DEPTH):0]       stack_level,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  LEVEL_FULL = LVL_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_INIT    = ADDR_W'(RESET_PC);

    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b01110;
    localparam logic [4:0] OP_BNE  = 5'b01111;

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_JUMP = 2'b01;
    localparam logic [1:0] SEL_BR   = 2'b10;
    localparam logic [1:0] SEL_RET  = 2'b11;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [18:0]       ir_q, ir_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              push;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_m1;
    logic [ADDR_W-1:0] target;
    logic [4:0]        ir_op;

    assign ir_op    = ir_q[18:14];
    assign target   = ir_q[ADDR_W-1:0];
    assign level_m1 = level_q - LVL_W'(1);
    // Low bits of the level give the wrapped slot; an empty pop reads slot DEPTH-1.
    assign wr_ptr   = level_q[PTR_W-1:0];
    assign rd_ptr   = level_m1[PTR_W-1:0];

    // Next-state decode: branch decisions use the ir held before this edge.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = load_ir ? imem_rdata : ir_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (pc_enable) begin
            case (pc_sel)
                SEL_INC: pc_d = pc_q + ADDR_W'(1);
                SEL_JUMP: begin
                    pc_d = target;
                    if (ir_op == OP_CALL) begin
`ifdef PC_STACK_CHECK_EN
                        if (level_q == LEVEL_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            level_d = level_q + LVL_W'(1);
                        end
`else
                        push = 1'b1;
                        if (level_q != LEVEL_FULL) level_d = level_q + LVL_W'(1);
`endif
                    end
                end
                SEL_BR: begin
                    if ((ir_op == OP_BEQ && zero_flag) || (ir_op == OP_BNE && !zero_flag))
                        pc_d = target;
                end
                SEL_RET: begin
`ifdef PC_STACK_CHECK_EN
                    if (level_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[rd_ptr];
                        level_d = level_m1;
                    end
`else
                    pc_d = stack_q[rd_ptr];
                    if (level_q != '0) level_d = level_m1;
`endif
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    // Architectural registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_INIT;
            ir_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; contents are not reset, only the level is.
    always_ff @(posedge clk) begin
        if (push) stack_q[wr_ptr] <= pc_q;
    end

    assign pc              = pc_q;
    assign imem_addr       = pc_q;
    assign ir              = ir_q;
    assign opcode          = ir_q[18:14];
    assign stack_level     = level_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    localparam int AW     = 14;
    localparam int DEPTH  = 8;
    localparam int PC_MOD = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_enable;
    logic [1:0]  pc_sel;
    logic        load_ir;
    logic        zero_flag;
    logic [18:0] imem_rdata;
    logic [AW-1:0] imem_addr;
    logic [AW-1:0] pc;
    logic [18:0] ir;
    logic [4:0]  opcode;
    logic [3:0]  stack_level;
    logic        stack_overflow;
    logic        stack_underflow;

    logic [18:0] mem [PC_MOD];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_pc, m_ir, m_level, m_ovf, m_unf;
    int m_stack [DEPTH];

    pc_fetch_unit #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .pc_enable(pc_enable), .pc_sel(pc_sel),
        .load_ir(load_ir), .zero_flag(zero_flag), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc(pc), .ir(ir), .opcode(opcode),
        .stack_level(stack_level), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check_eq({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
        check_eq({tag, ".ir"}, 32'(ir), 32'(m_ir));
        check_eq({tag, ".op"}, 32'(opcode), 32'(m_ir / 16384));
        check_eq({tag, ".lvl"}, 32'(stack_level), 32'(m_level));
        check_eq({tag, ".ovf"}, 32'(stack_overflow), 32'(m_ovf));
        check_eq({tag, ".unf"}, 32'(stack_underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_level = 0; m_ovf = 0; m_unf = 0;
    endtask

    // One clock of the reference: all decisions come from the pre-edge state.
    task automatic model_step(input bit le, input bit pe, input int sel, input bit z);
        int op, tgt, nxt;
        op  = m_ir / 16384;
        tgt = m_ir % PC_MOD;
        nxt = m_pc;
        if (pe) begin
            case (sel)
                0: nxt = (m_pc + 1) % PC_MOD;
                1: begin
                    nxt = tgt;
                    if (op == 16) begin
`ifdef PC_STACK_CHECK_EN
                        if (m_level == DEPTH) m_ovf = 1;
                        else begin m_stack[m_level] = m_pc; m_level++; end
`else
                        m_stack[m_level % DEPTH] = m_pc;
                        if (m_level < DEPTH) m_level++;
`endif
                    end
                end
                2: if ((op == 14 && z) || (op == 15 && !z)) nxt = tgt;
                default: begin
`ifdef PC_STACK_CHECK_EN
                    if (m_level == 0) m_unf = 1;
                    else begin m_level--; nxt = m_stack[m_level]; end
`else
                    nxt = m_stack[(m_level + DEPTH - 1) % DEPTH];
                    if (m_level > 0) m_level--;
`endif
                end
            endcase
        end
        if (le) m_ir = int'(mem[m_pc]);
        m_pc = nxt;
    endtask

    task automatic step(input string tag, input bit le, input bit pe, input int sel, input bit z);
        load_ir = le; pc_enable = pe; pc_sel = 2'(sel); zero_flag = z;
        model_step(le, pe, sel, z);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Place a word at the current pc and latch it without moving the pc.
    task automatic set_ir(input logic [18:0] word);
        mem[m_pc] = word;
        step("setir", 1, 0, 1, 1);
    endtask

    task automatic apply_reset();
        reset = 1;
        load_ir = 0; pc_enable = 0; pc_sel = 0; zero_flag = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < PC_MOD; i++) mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) m_stack[i] = 0;
        reset = 1;
        #2;
        apply_reset();

        // three fetches
        mem[0] = 19'h0_1234; mem[1] = 19'h1_0005; mem[2] = 19'h2_3456;
        for (int i = 0; i < 3; i++) step("fetch", 1, 1, 0, 0);

        // JMP, BEQ, BNE
        set_ir({5'b00001, 14'h0100});
        step("hold", 0, 0, 1, 0);
        step("jmp", 0, 1, 1, 0);
        set_ir({5'b01110, 14'h0200});
        step("beq_nt", 0, 1, 2, 0);
        step("beq_t", 0, 1, 2, 1);
        set_ir({5'b01111, 14'h0200});
        step("bne_nt", 0, 1, 2, 1);
        step("bne_t", 0, 1, 2, 0);
        set_ir({5'b00011, 14'h0222});
        step("br_other", 0, 1, 2, 1);

        // nested CALL / RET
        set_ir({5'b00001, 14'h0011});
        step("jmp11", 0, 1, 1, 0);
        set_ir({5'b10000, 14'h0050});
        step("call1", 0, 1, 1, 0);
        set_ir({5'b10000, 14'h0070});
        step("call2", 0, 1, 1, 0);
        step("ret1", 0, 1, 3, 0);
        step("ret2", 0, 1, 3, 0);

        // PC wrap
        set_ir({5'b00001, 14'h3FFF});
        step("jmp_top", 0, 1, 1, 0);
        step("wrap", 0, 1, 0, 0);

        // overflow / underflow
        set_ir({5'b10000, 14'h0300});
        for (int i = 0; i < 9; i++) step("call_n", 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step("ret_n", 0, 1, 3, 0);

        // reset asserted in the middle of a CALL cycle
        set_ir({5'b10000, 14'h0123});
        step("call_pre", 0, 1, 1, 0);
        load_ir = 1; pc_enable = 1; pc_sel = 2'b01; zero_flag = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 0;
        load_ir = 0; pc_enable = 0;

        // random program and random control strobes
        for (int i = 0; i < PC_MOD; i++) begin
            logic [4:0] op;
            case ($urandom_range(0, 4))
                0: op = 5'b10000;
                1: op = 5'b01110;
                2: op = 5'b01111;
                3: op = 5'b00001;
                default: op = 5'($urandom);
            endcase
            mem[i] = {op, 14'($urandom)};
        end
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
